// File: rtl/result_serializer.sv
// Captures WIDTH compressor result columns on a strobe and streams them
// LSB-first over a one-bit valid/ready link, closing each frame with even parity.
module result_serializer #(
    parameter int WIDTH = 31,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dst,
    input  logic             cap,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IDXW = $clog2(WIDTH + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [IDXW-1:0]  r_idx;
    logic             r_par;
    logic             r_ovr;
    logic [CNT_W-1:0] r_cnt;

    logic w_shift;
    logic w_last;
    logic w_xfer;

    assign w_shift = (r_state == S_SHIFT);
    assign w_last  = (r_idx == LAST_IDX);
    assign w_xfer  = w_shift & sout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_idx    <= '0;
            r_par    <= 1'b0;
            r_ovr    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cap) begin
                        r_shadow <= dst;
                        r_par    <= ^dst;
                        r_idx    <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_xfer && w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                        // a capture on the accepted parity beat starts the next frame with no bubble
                        if (cap) begin
                            r_shadow <= dst;
                            r_par    <= ^dst;
                            r_idx    <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_shadow <= {1'b0, r_shadow[WIDTH-1:1]};
                            r_idx    <= r_idx + 1'b1;
                        end
                        if (cap) begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sout       = w_shift & (w_last ? r_par : r_shadow[0]);
    assign sout_valid = w_shift;
    assign sout_last  = w_shift & w_last;
    assign busy       = w_shift;
    assign overrun    = r_ovr;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: frame vectors from a table, expected beats
// queued at capture and popped as the DUT hands them over.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [30:0] dst = '0;
    logic        cap = 1'b0;
    logic        sout_ready = 1'b1;

    logic        sout, sout_valid, sout_last, busy, overrun;
    logic [15:0] frame_cnt;
    logic        sout2, sout_valid2, sout_last2, busy2, overrun2;
    logic [1:0]  frame_cnt2;

    result_serializer #(.WIDTH(31), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .dst(dst), .cap(cap),
        .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last),
        .sout_ready(sout_ready), .busy(busy), .overrun(overrun),
        .frame_cnt(frame_cnt)
    );

    result_serializer #(.WIDTH(31), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .dst(dst), .cap(cap),
        .sout(sout2), .sout_valid(sout_valid2), .sout_last(sout_last2),
        .sout_ready(sout_ready), .busy(busy2), .overrun(overrun2),
        .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic l;
    } beat_t;

    typedef struct {
        logic [30:0] dst;
        int          rmode;
        int          cap_beat;
        logic [30:0] cap_dst;
        bit          b2b;
        logic        exp_par;
        logic        exp_par_b;
    } vec_t;

    beat_t q[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;
    int    acc = 0;
    int    exp_cnt = 0;
    bit    exp_ovr = 1'b0;
    bit    pv_stall = 1'b0;
    logic [2:0] pv_out = '0;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // sampled at the falling edge; a beat seen valid&ready here transfers on the next rise
    task automatic sample();
        beat_t e;
        if (!rst && pv_stall)
            chk({sout, sout_last, sout_valid} == pv_out, "stall_hold",
                {29'd0, sout, sout_last, sout_valid}, {29'd0, pv_out});
        pv_stall = !rst && sout_valid && !sout_ready;
        pv_out   = {sout, sout_last, sout_valid};
        if (!rst && sout_valid && sout_ready) begin
            if (q.size() == 0) begin
                chk(1'b0, "extra_beat", {31'd0, sout}, 32'd0);
            end else begin
                e = q.pop_front();
                chk({sout, sout_last} == {e.b, e.l}, "beat",
                    {30'd0, sout, sout_last}, {30'd0, e.b, e.l});
            end
            acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [30:0] d, input logic p);
        for (int i = 0; i < 31; i++) q.push_back('{d[i], 1'b0});
        q.push_back('{p, 1'b1});
    endtask

    task automatic start_cap(input logic [30:0] d);
        dst = d;
        cap = 1'b1;
        tick();
        cap = 1'b0;
        chk(sout_valid && busy && !sout_last && sout == d[0], "cap_latency",
            {28'd0, sout_valid, busy, sout_last, sout},
            {28'd0, 1'b1, 1'b1, 1'b0, d[0]});
    endtask

    task automatic check_end();
        chk(busy == 1'b0, "busy_end", {31'd0, busy}, 32'd0);
        chk(frame_cnt == exp_cnt[15:0], "frame_cnt",
            {16'd0, frame_cnt}, {16'd0, exp_cnt[15:0]});
        chk(frame_cnt2 == exp_cnt[1:0], "frame_cnt_w2",
            {30'd0, frame_cnt2}, {30'd0, exp_cnt[1:0]});
        chk(overrun == exp_ovr, "overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    task automatic run_frame(input vec_t v);
        int a0;
        int n;
        push_frame(v.dst, v.exp_par);
        if (v.b2b) push_frame(v.cap_dst, v.exp_par_b);
        start_cap(v.dst);
        a0 = acc;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            case (v.rmode)
                0:       sout_ready = 1'b1;
                1:       sout_ready = (n % 4 == 0) || (n % 4 == 3);
                default: sout_ready = 1'($urandom_range(1));
            endcase
            if (v.cap_beat >= 0 && acc - a0 == v.cap_beat) begin
                cap = 1'b1;
                dst = v.cap_dst;
            end else begin
                cap = 1'b0;
                dst = 31'($urandom);
            end
            tick();
            if (q.size() > 0)
                chk(sout_valid == 1'b1, "valid_hold", {31'd0, sout_valid}, 32'd1);
            n++;
        end
        cap = 1'b0;
        sout_ready = 1'b1;
        if (n >= 400) begin
            chk(1'b0, "frame_timeout", q.size(), 32'd0);
            q.delete();
        end
        exp_cnt += v.b2b ? 2 : 1;
        if (v.cap_beat >= 0 && !v.b2b) exp_ovr = 1'b1;
        check_end();
    endtask

    initial begin
        int a0;
        int n;
        int seq[5];
        vec_t v;
        vecs[0] = '{31'h00000001, 0, -1, 31'h0,        1'b0, 1'b1, 1'b0};
        vecs[1] = '{31'h7FFFFFFF, 1, -1, 31'h0,        1'b0, 1'b1, 1'b0};
        vecs[2] = '{31'h0000AAAA, 0,  4, 31'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{31'h00000001, 0, 31, 31'h00000003, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{31'h12345678, 2, -1, 31'h0,        1'b0, 1'b1, 1'b0};
        vecs[5] = '{31'h55555555, 2, -1, 31'h0,        1'b0, 1'b0, 1'b0};
        vecs[6] = '{31'h00000000, 0, -1, 31'h0,        1'b0, 1'b0, 1'b0};
        seq = '{1, 2, 3, 0, 1};

        #2 rst = 1'b1;
        #1;
        chk({sout, sout_valid, sout_last, busy, overrun} == 5'b0, "reset_outs",
            {27'd0, sout, sout_valid, sout_last, busy, overrun}, 32'd0);
        chk(frame_cnt == 16'd0, "reset_cnt", {16'd0, frame_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // abort a frame with reset while beat 10 is on the wire
        push_frame(31'h00F0F0F0, 1'b0);
        start_cap(31'h00F0F0F0);
        a0 = acc;
        n = 0;
        while (acc - a0 < 9 && n < 100) begin
            tick();
            n++;
        end
        chk(acc - a0 == 9, "midrst_reach", acc - a0, 32'd9);
        #2 rst = 1'b1;
        #1;
        chk({sout, sout_valid, sout_last, busy, overrun} == 5'b0, "midrst_outs",
            {27'd0, sout, sout_valid, sout_last, busy, overrun}, 32'd0);
        chk(frame_cnt == 16'd0, "midrst_cnt", {16'd0, frame_cnt}, 32'd0);
        q.delete();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        tick();

        v = '{31'h00000005, 0, -1, 31'h0, 1'b0, 1'b0, 1'b0};
        run_frame(v);
        chk(frame_cnt2 == 2'(seq[0]), "wrap_seq", {30'd0, frame_cnt2}, seq[0]);
        run_frame(vecs[0]);
        chk(frame_cnt2 == 2'(seq[1]), "wrap_seq", {30'd0, frame_cnt2}, seq[1]);
        run_frame(vecs[1]);
        chk(frame_cnt2 == 2'(seq[2]), "wrap_seq", {30'd0, frame_cnt2}, seq[2]);
        run_frame(vecs[4]);
        chk(frame_cnt2 == 2'(seq[3]), "wrap_seq", {30'd0, frame_cnt2}, seq[3]);
        run_frame(vecs[5]);
        chk(frame_cnt2 == 2'(seq[4]), "wrap_seq", {30'd0, frame_cnt2}, seq[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
